neuron_mac_seq: RTL and testbench

NEURON_MAC_SEQ -- requirements
Module: neuron_mac_seq

---
 rtl/neuron_pkg.sv | 14 +
 rtl/mac_pipe.sv | 34 +++
 rtl/neuron_mac_seq.sv | 117 +++++++++++
 tb/tb_neuron_mac_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared definitions for the sequential neuron MAC: FSM state encoding and
// the default accumulator width.
package neuron_pkg;

    localparam int DEFAULT_ACC_W = 20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/mac_pipe.sv
// Signed 8x8 multiply-accumulate stage with synchronous clear and enable.
// The 16-bit product is sign-extended and the sum wraps in two's complement.
module mac_pipe
    import neuron_pkg::*;
#(
    parameter int ACC_W = DEFAULT_ACC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [7:0]       w,
    input  logic signed [7:0]       x,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [15:0] prod_s;

    assign prod_s = w * x;

    // accumulator register: clear wins over enable so a new run never sees stale terms
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod_s);
        end else begin
            acc <= acc;
        end
    end

endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential neuron: streams N_INPUTS weight/feature pairs from 1-cycle
// synchronous memories, accumulates their dot product and reports clamp/trigger.
module neuron_mac_seq
    import neuron_pkg::*;
#(
    parameter int N_INPUTS  = 16,
    parameter int ADDR_W    = 8,
    parameter int ACC_W     = DEFAULT_ACC_W,
    parameter int SHIFT     = 0,
    parameter int THRESHOLD = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic signed [7:0]       w_data,
    input  logic signed [7:0]       x_data,
    output logic                    busy,
    output logic                    done,
    output logic signed [ACC_W-1:0] acc_out,
    output logic [7:0]              act_out,
    output logic                    trigger
);

    localparam logic [ADDR_W-1:0]       LAST_ADDR = ADDR_W'(N_INPUTS - 1);
    localparam logic [ADDR_W-1:0]       ADDR_ONE  = ADDR_W'(1);
    localparam logic signed [ACC_W-1:0] ACT_MAX   = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] THR       = ACC_W'(THRESHOLD);

    state_t                    state_r;
    logic                      valid_r;
    logic                      acc_clr_s;
    logic signed [ACC_W-1:0]   acc_s;
    logic signed [ACC_W-1:0]   shifted_s;
    logic [7:0]                act_next_s;
    logic                      trig_next_s;

    assign acc_clr_s = (state_r == ST_IDLE) && start;

    mac_pipe #(.ACC_W(ACC_W)) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr_s),
        .en  (valid_r),
        .w   (w_data),
        .x   (x_data),
        .acc (acc_s)
    );

    assign shifted_s = acc_s >>> SHIFT;

    // activation clamp to [0,127] and signed threshold compare on the final sum
    always_comb begin
        act_next_s  = 8'd0;
        trig_next_s = (acc_s > THR);
        if (shifted_s[ACC_W-1]) begin
            act_next_s = 8'd0;
        end else if (shifted_s > ACT_MAX) begin
            act_next_s = 8'd127;
        end else begin
            act_next_s = shifted_s[7:0];
        end
    end

    // control FSM, address generator, valid pipeline and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            rd_addr <= '0;
            valid_r <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            acc_out <= '0;
            act_out <= 8'd0;
            trigger <= 1'b0;
        end else begin
            done    <= 1'b0;
            valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    rd_addr <= '0;
                    if (start) begin
                        state_r <= ST_RUN;
                        busy    <= 1'b1;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // data for this address arrives next cycle, so tag it valid then
                    valid_r <= 1'b1;
                    if (rd_addr == LAST_ADDR) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        rd_addr <= rd_addr + ADDR_ONE;
                    end
                end
                ST_DRAIN: begin
                    state_r <= ST_FINISH;
                end
                ST_FINISH: begin
                    acc_out <= acc_s;
                    act_out <= act_next_s;
                    trigger <= trig_next_s;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Self-checking bench: 1-cycle synchronous ROM/feature models, directed and
// random runs compared against a plain-arithmetic dot-product model.
module tb_neuron_mac_seq;

    localparam int N   = 4;
    localparam int AW  = 8;
    localparam int AW_ = 20;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [AW-1:0]         rd_addr;
    logic signed [7:0]     w_data;
    logic signed [7:0]     x_data;
    logic                  busy;
    logic                  done;
    logic signed [AW_-1:0] acc_out;
    logic [7:0]            act_out;
    logic                  trigger;

    logic                  start1;
    logic [AW-1:0]         rd_addr1;
    logic signed [7:0]     w_data1;
    logic signed [7:0]     x_data1;
    logic                  busy1;
    logic                  done1;
    logic signed [AW_-1:0] acc_out1;
    logic [7:0]            act_out1;
    logic                  trigger1;

    logic signed [7:0] w_mem [256];
    logic signed [7:0] x_mem [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    neuron_mac_seq #(.N_INPUTS(N), .ADDR_W(AW), .ACC_W(AW_), .SHIFT(0), .THRESHOLD(64)) dut (
        .clk(clk), .rst(rst), .start(start), .rd_addr(rd_addr),
        .w_data(w_data), .x_data(x_data), .busy(busy), .done(done),
        .acc_out(acc_out), .act_out(act_out), .trigger(trigger)
    );

    neuron_mac_seq #(.N_INPUTS(1), .ADDR_W(AW), .ACC_W(AW_), .SHIFT(0), .THRESHOLD(64)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .rd_addr(rd_addr1),
        .w_data(w_data1), .x_data(x_data1), .busy(busy1), .done(done1),
        .acc_out(acc_out1), .act_out(act_out1), .trigger(trigger1)
    );

    // synchronous ROM and feature buffer, one-cycle read latency
    always @(posedge clk) begin
        w_data  <= w_mem[rd_addr];
        x_data  <= x_mem[rd_addr];
        w_data1 <= w_mem[rd_addr1];
        x_data1 <= x_mem[rd_addr1];
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // reference: dot product over the first n entries, wrapped to 20 bits
    task automatic model(input int n, output int e_acc, output int e_act, output int e_trig);
        int sum;
        logic signed [AW_-1:0] wrapped;
        sum = 0;
        for (int i = 0; i < n; i++) sum += int'(w_mem[i]) * int'(x_mem[i]);
        wrapped = sum[AW_-1:0];
        e_acc  = int'(wrapped);
        e_act  = (e_acc < 0) ? 0 : ((e_acc > 127) ? 127 : e_acc);
        e_trig = (e_acc > 64) ? 1 : 0;
    endtask

    task automatic load(input int w0, input int w1, input int w2, input int w3,
                        input int x0, input int x1, input int x2, input int x3);
        w_mem[0] = 8'(w0); w_mem[1] = 8'(w1); w_mem[2] = 8'(w2); w_mem[3] = 8'(w3);
        x_mem[0] = 8'(x0); x_mem[1] = 8'(x1); x_mem[2] = 8'(x2); x_mem[3] = 8'(x3);
    endtask

    task automatic start_run();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_check(input string tag);
        int lat, e_acc, e_act, e_trig;
        start_run();
        wait_done(20, lat);
        check({tag, "_lat"}, 32'(lat), N + 2);
        model(N, e_acc, e_act, e_trig);
        check({tag, "_acc"}, 32'(acc_out), e_acc);
        check({tag, "_act"}, 32'({24'd0, act_out}), e_act);
        check({tag, "_trig"}, 32'({31'd0, trigger}), e_trig);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'({31'd0, done}), 0);
    endtask

    initial begin
        int lat, lat2, cnt, e_acc, e_act, e_trig;
        for (int i = 0; i < 256; i++) begin
            w_mem[i] = 8'sd0;
            x_mem[i] = 8'sd0;
        end
        rst    = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'({31'd0, busy}), 0);
        check("rst_done", 32'({31'd0, done}), 0);
        check("rst_addr", 32'(rd_addr), 0);
        check("rst_acc", 32'(acc_out), 0);
        check("rst_act", 32'({24'd0, act_out}), 0);
        check("rst_trig", 32'({31'd0, trigger}), 0);
        @(negedge clk);
        rst = 1'b0;

        // basic run with address sequence and exact done timing
        load(1, 2, 3, 4, 1, 1, 1, 1);
        start_run();
        check("addr_e0", 32'(rd_addr), 0);
        check("busy_run", 32'({31'd0, busy}), 1);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check("addr_seq", 32'(rd_addr), k);
        end
        wait_done(10, lat);
        check("basic_lat", 32'(lat + 3), 6);
        check("basic_acc", 32'(acc_out), 10);
        check("basic_act", 32'({24'd0, act_out}), 10);
        check("basic_trig", 32'({31'd0, trigger}), 0);
        check("idle_busy", 32'({31'd0, busy}), 0);

        load(127, 127, 127, 127, 127, 127, 127, 127);
        run_check("maxpos");
        check("maxpos_lit", 32'(acc_out), 64516);
        load(-128, -128, -128, -128, 127, 127, 127, 127);
        run_check("negmix");
        check("negmix_lit", 32'(acc_out), -65024);
        load(-128, -128, -128, -128, -128, -128, -128, -128);
        run_check("negneg");
        check("negneg_lit", 32'(acc_out), 65536);
        load(64, 0, 0, 0, 1, 1, 1, 1);
        run_check("thr_eq");
        load(64, 1, 0, 0, 1, 1, 1, 1);
        run_check("thr_above");

        // start pulses while busy must be ignored
        load(1, 2, 3, 4, 2, 2, 2, 2);
        start_run();
        cnt = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            start = (k == 2 || k == 4);
            @(posedge clk);
            #1;
            if (done === 1'b1) cnt++;
        end
        start = 1'b0;
        check("busy_start_ignored", 32'(cnt), 1);
        check("busy_start_acc", 32'(acc_out), 20);
        load(1, 2, 3, 4, 0, 0, 0, 0);
        run_check("cleared");

        // start held high across done begins the next run right after IDLE
        @(negedge clk);
        start = 1'b1;
        wait_done(20, lat);
        wait_done(20, lat2);
        start = 1'b0;
        check("held_start_gap", 32'(lat2), N + 3);
        @(posedge clk);
        #1;

        // reset in the middle of a run
        load(1, 2, 3, 4, 1, 1, 1, 1);
        run_check("pre_abort");
        start_run();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", 32'({31'd0, busy}), 0);
        check("abort_addr", 32'(rd_addr), 0);
        check("abort_acc", 32'(acc_out), 0);
        check("abort_act", 32'({24'd0, act_out}), 0);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) cnt++;
        end
        check("abort_no_done", 32'(cnt), 0);
        run_check("post_abort");

        // reset beats start on the same edge
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("rst_prio_busy", 32'({31'd0, busy}), 0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;

        // randomized runs
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) begin
                w_mem[i] = 8'($urandom_range(0, 255));
                x_mem[i] = 8'($urandom_range(0, 255));
            end
            run_check("rand");
        end

        // single-input instance
        w_mem[0] = -8'sd7;
        x_mem[0] = -8'sd11;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (done1 === 1'b1) begin
                lat = k;
                break;
            end
        end
        model(1, e_acc, e_act, e_trig);
        check("n1_lat", 32'(lat), 3);
        check("n1_acc", 32'(acc_out1), e_acc);
        check("n1_act", 32'({24'd0, act_out1}), e_act);
        check("n1_trig", 32'({31'd0, trigger1}), e_trig);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
